// File: rtl/seg7_display_scanner.sv
// Four-digit multiplexed 7-segment scanner with optional leading-zero blanking.
// Digits are latched on load; an/seg are registered from the current slot and latch.
module seg7_display_scanner #(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] res_d3,
    input  logic [3:0] res_d2,
    input  logic [3:0] res_d1,
    input  logic [3:0] res_d0,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [1:0] slot
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0]   r_count;
    logic [1:0]      r_slot;
    logic [3:0][3:0] r_latch;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_tick;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [3:0]      w_an;
    logic [6:0]      w_seg;

    assign w_tick = (r_count == LAST);

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_digit = r_latch[r_slot];
        w_blank = 1'b0;
        if (BLANK_LZ) begin
            // A digit is blank only when it and every more-significant digit are zero.
            case (r_slot)
                2'd3:    w_blank = (r_latch[3] == 4'd0);
                2'd2:    w_blank = ((r_latch[3] | r_latch[2]) == 4'd0);
                2'd1:    w_blank = ((r_latch[3] | r_latch[2] | r_latch[1]) == 4'd0);
                default: w_blank = 1'b0;
            endcase
        end

        case (w_digit)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase
        w_an = ~(4'b0001 << r_slot);

        if (w_blank) begin
            w_an  = 4'hF;
            w_seg = 7'h7F;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_slot  <= 2'd0;
            r_latch <= '0;
            r_an    <= 4'hF;
            r_seg   <= 7'h7F;
        end else begin
            r_count <= w_tick ? '0 : r_count + CW'(1);
            if (w_tick) begin
                r_slot <= r_slot + 2'd1;
            end
            if (load) begin
                r_latch <= {res_d3, res_d2, res_d1, res_d0};
            end
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign slot = r_slot;

endmodule

// File: doc/seg7_display_scanner.md
SEG7_DISPLAY_SCANNER -- requirements
Module: seg7_display_scanner

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2 to 2^20.
REQ-002 Parameter BLANK_LZ, default 1, 1 enables leading-zero blanking.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 res_d3  input  4  BCD thousands digit from the BCD result stage.
REQ-006 res_d2  input  4  BCD hundreds digit.
REQ-007 res_d1  input  4  BCD tens digit.
REQ-008 res_d0  input  4  BCD units digit.
REQ-009 load  input  1  capture res_d3..res_d0 into the display latch.
REQ-010 an  output  4  digit enables, active-low; an[k] selects digit k.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 slot  output  2  current scan index.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1, wraps to 0; internal tick is high in the cycle where the count equals CLK_DIV-1.
REQ-014 slot advances 0->1->2->3->0 on each tick edge; no other event changes slot except rst.
REQ-015 load=1 at an edge writes all four inputs to the latch on that edge; load=0 holds the latch; inputs are otherwise ignored.
REQ-016 an and seg are registered from slot and the latch: a one-cycle latency, so they reflect the slot/latch values present before each edge.
REQ-017 Slot k drives an = all ones except bit k = 0, and seg = decode(latched digit k).
REQ-018 Decode, active-low hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
REQ-019 Latched digit value 10..15 decodes to dash 3F; it is never blanked, and it counts as non-zero for blanking.
REQ-020 Blanking with BLANK_LZ=1: digit 3 is blank if d3=0; digit 2 is blank if d3=d2=0; digit 1 is blank if d3=d2=d1=0; digit 0 is never blank.
REQ-021 Blanking with BLANK_LZ=0: no digit is ever blank.
REQ-022 Blank slot: an = 4'hF and seg = 7'h7F for that slot's full duration; slot timing is unchanged.
REQ-023 Simultaneous load and tick: both take effect on the same edge; the next outputs use the new slot and the new latch.
REQ-024 A load mid-slot takes effect on seg one cycle later without altering the prescaler or slot.
REQ-025 At most one an bit is low in any cycle.

Reset
REQ-026 rst=1 at an edge clears the prescaler to 0, slot to 0 and the latch to 0000; it sets an=4'hF and seg=7'h7F.
REQ-027 rst has priority over load and tick; reset asserted mid-slot restarts the slot timing from count 0.
REQ-028 First edge after rst deasserts: an=4'hE, seg=40 (digit 0 shows "0"); the first slot advance occurs on the CLK_DIV-th edge after release.

Verification (CLK_DIV=4 unless noted)
REQ-029 Reset, no load -> an cycles through E, then F for 12 cycles (slots 1-3 blank), seg=40 in slot 0 and 7F elsewhere.
REQ-030 Load 1,2,3,4 (d3..d0) -> the repeating 16-cycle pattern an=E/D/B/7 with seg=19/30/24/79, each held for 4 cycles.
REQ-031 Load 0,0,5,0 -> slot 0 gives seg=40, slot 1 gives seg=12, slots 2 and 3 give an=F; with BLANK_LZ=0 the same digits give slot 2 and slot 3 seg=40.
REQ-032 Load d3=12, others 0 -> slot 3 gives seg=3F; slots 2 and 1 give seg=40, not blank.
REQ-033 Assert load on the tick cycle with new digits -> the next slot's seg shows the new digit; assert rst during slot 2 -> next edge an=F, the following edge an=E, and the prescaler restarts.
REQ-034 Scoreboard every cycle: an is one-hot-low or F, and seg matches the REQ-018 table from the latched value.
